// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential divider.
package divider_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Width of an iteration counter that must be able to hold the value m.
    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the partial remainder left, bring in
// the next dividend bit (MSB of quo), trial-subtract the divisor at M+1 bits.
module div_step
    import divider_pkg::*;
#(
    parameter int M = 32
) (
    input  logic [M-1:0] rem,
    input  logic [M-1:0] quo,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] rem_next,
    output logic [M-1:0] quo_next
);

    logic [M:0] shifted;
    logic [M:0] diff;

    // The remainder is always below the divisor, so the shifted value fits in
    // M+1 bits and the sign of the M+1-bit difference decides the quotient bit.
    always_comb begin
        shifted = {rem, quo[M-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[M]) begin
            rem_next = diff[M-1:0];
            quo_next = {quo[M-2:0], 1'b1};
        end else begin
            rem_next = shifted[M-1:0];
            quo_next = {quo[M-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Operates on magnitudes and fixes up the signs in a final cycle; divide by
// zero and MIN / -1 are detected at accept and bypass the iteration loop.
module seq_divider
    import divider_pkg::*;
#(
    parameter int M           = 32,
    parameter int SIGNED_MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int            CW        = cnt_width(M);
    localparam logic [CW-1:0] LAST_ITER = CW'(M - 1);
    localparam logic [M-1:0]  MIN_VAL   = {1'b1, {(M-1){1'b0}}};

    div_state_t    state_reg;
    logic [M-1:0]  rem_reg;
    logic [M-1:0]  quo_reg;
    logic [M-1:0]  dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          neg_q_reg;
    logic          neg_r_reg;
    logic          dz_reg;
    logic          ov_reg;

    logic [M-1:0]  rem_next;
    logic [M-1:0]  quo_next;

    logic          sign_a;
    logic          sign_b;
    logic          is_zero;
    logic          is_ovf;
    logic [M-1:0]  mag_a;
    logic [M-1:0]  mag_b;

    // Operand classification and magnitudes; |MIN| is 2^(M-1), which still
    // fits in M unsigned bits, so no extra width is needed here.
    always_comb begin
        sign_a  = (SIGNED_MODE != 0) && dividend[M-1];
        sign_b  = (SIGNED_MODE != 0) && divisor[M-1];
        is_zero = (divisor == '0);
        is_ovf  = (SIGNED_MODE != 0) && (dividend == MIN_VAL) && (divisor == '1);
        mag_a   = sign_a ? (~dividend + 1'b1) : dividend;
        mag_b   = sign_b ? (~divisor + 1'b1) : divisor;
    end

    div_step #(.M(M)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvs_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dz_reg      <= 1'b0;
            ov_reg      <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        cnt_reg  <= '0;
                        dvs_reg  <= mag_b;
                        dz_reg   <= is_zero;
                        ov_reg   <= is_ovf && !is_zero;
                        if (is_zero) begin
                            // Special results are preloaded already signed.
                            quo_reg   <= '1;
                            rem_reg   <= dividend;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= FIX;
                        end else if (is_ovf) begin
                            quo_reg   <= MIN_VAL;
                            rem_reg   <= '0;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= FIX;
                        end else begin
                            quo_reg   <= mag_a;
                            rem_reg   <= '0;
                            neg_q_reg <= sign_a ^ sign_b;
                            neg_r_reg <= sign_a;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
                    remainder   <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                    div_by_zero <= dz_reg;
                    overflow    <= ov_reg;
                    state_reg   <= DONE;
                end
                DONE: begin
                    // First DONE cycle raises out_valid; afterwards wait for
                    // the consumer with results frozen.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and randomised check of seq_divider in three configurations:
// signed M=32, unsigned M=32, signed M=8.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        out_ready;
    logic [2:0]  iv;

    logic        rdy_s32, vld_s32, dz_s32, ovf_s32;
    logic [31:0] q_s32, r_s32;
    logic        rdy_u32, vld_u32, dz_u32, ovf_u32;
    logic [31:0] q_u32, r_u32;
    logic        rdy_s8, vld_s8, dz_s8, ovf_s8;
    logic [7:0]  q_s8, r_s8;

    int          cur;
    logic        rdy, vld, dz, ovf;
    logic [31:0] q, r;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_divider #(.M(32), .SIGNED_MODE(1)) u_s32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy_s32),
        .dividend(a32), .divisor(b32), .out_valid(vld_s32), .out_ready(out_ready),
        .quotient(q_s32), .remainder(r_s32), .div_by_zero(dz_s32), .overflow(ovf_s32)
    );

    seq_divider #(.M(32), .SIGNED_MODE(0)) u_u32 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy_u32),
        .dividend(a32), .divisor(b32), .out_valid(vld_u32), .out_ready(out_ready),
        .quotient(q_u32), .remainder(r_u32), .div_by_zero(dz_u32), .overflow(ovf_u32)
    );

    seq_divider #(.M(8), .SIGNED_MODE(1)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy_s8),
        .dividend(a32[7:0]), .divisor(b32[7:0]), .out_valid(vld_s8), .out_ready(out_ready),
        .quotient(q_s8), .remainder(r_s8), .div_by_zero(dz_s8), .overflow(ovf_s8)
    );

    // View of the instance currently under test.
    always_comb begin
        rdy = rdy_s32; vld = vld_s32; q = q_s32; r = r_s32; dz = dz_s32; ovf = ovf_s32;
        case (cur)
            1: begin
                rdy = rdy_u32; vld = vld_u32; q = q_u32; r = r_u32; dz = dz_u32; ovf = ovf_u32;
            end
            2: begin
                rdy = rdy_s8; vld = vld_s8; q = {24'h0, q_s8}; r = {24'h0, r_s8};
                dz = dz_s8; ovf = ovf_s8;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b, output bit ok);
        int t;
        ok  = 1'b0;
        cur = sel;
        @(negedge clk);
        a32 = a;
        b32 = b;
        iv  = 3'b000;
        iv[sel] = 1'b1;
        t = 0;
        while (!rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) begin
            iv = 3'b000;
            chk("issue_in_ready_timeout", 32'(rdy), 32'd1);
        end else begin
            @(posedge clk);
            #1 iv = 3'b000;
            ok = 1'b1;
            n_vec++;
        end
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (vld) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 32'(vld), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_handshake", 32'(rdy), 32'd1);
        chk("out_valid_after_handshake", 32'(vld), 32'd0);
    endtask

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] qo, output logic [31:0] ro,
                          output logic dzo, output logic ovo, output int lat, output bit ok);
        issue(sel, a, b, ok);
        lat = 0;
        qo = 'x; ro = 'x; dzo = 1'bx; ovo = 1'bx;
        if (ok) begin
            wait_valid(lat, ok);
            if (ok) begin
                qo = q; ro = r; dzo = dz; ovo = ovf;
                consume();
            end
        end
    endtask

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[21];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gq, gr;
        logic        gdz, gov;
        int          lat;
        bit          ok;
        int          sa, sb;
        logic signed [7:0] a8, b8, eq8, er8;

        vecs[0]  = '{0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 34};
        vecs[1]  = '{0, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 1'b0, 34};
        vecs[2]  = '{0, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 1'b0, 34};
        vecs[3]  = '{0, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 1'b0, 34};
        vecs[4]  = '{0, 32'd55,        32'd0,         32'hFFFFFFFF,  32'd55,        1'b1, 1'b0, 2};
        vecs[5]  = '{0, 32'hFFFFFFC9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFC9,  1'b1, 1'b0, 2};
        vecs[6]  = '{0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b1, 2};
        vecs[7]  = '{0, 32'h80000000,  32'd7,         32'hEDB6DB6E,  32'hFFFFFFFE,  1'b0, 1'b0, 34};
        vecs[8]  = '{0, 32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0, 1'b0, 34};
        vecs[9]  = '{0, 32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 1'b0, 34};
        vecs[10] = '{0, 32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0, 1'b0, 34};
        vecs[11] = '{0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0, 34};
        vecs[12] = '{1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b0, 34};
        vecs[13] = '{1, 32'hFFFFFFFF,  32'd16,        32'h0FFFFFFF,  32'd15,        1'b0, 1'b0, 34};
        vecs[14] = '{1, 32'd55,        32'd0,         32'hFFFFFFFF,  32'd55,        1'b1, 1'b0, 2};
        vecs[15] = '{2, 32'h0000009C,  32'd7,         32'h000000F2,  32'h000000FE,  1'b0, 1'b0, 10};
        vecs[16] = '{2, 32'h00000080,  32'h000000FF,  32'h00000080,  32'd0,         1'b0, 1'b1, 2};
        vecs[17] = '{2, 32'h00000080,  32'd3,         32'h000000D6,  32'h000000FE,  1'b0, 1'b0, 10};
        vecs[18] = '{2, 32'h0000007F,  32'h00000080,  32'd0,         32'h0000007F,  1'b0, 1'b0, 10};
        vecs[19] = '{2, 32'h00000080,  32'h00000080,  32'd1,         32'd0,         1'b0, 1'b0, 10};
        vecs[20] = '{2, 32'd5,         32'd0,         32'h000000FF,  32'd5,         1'b1, 1'b0, 2};

        rst = 1'b1; iv = 3'b000; out_ready = 1'b0; a32 = '0; b32 = '0; cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Reset state
        cur = 0;
        #1;
        chk("reset_in_ready", 32'(rdy), 32'd1);
        chk("reset_out_valid", 32'(vld), 32'd0);
        chk("reset_quotient", q, 32'd0);
        chk("reset_remainder", r, 32'd0);
        chk("reset_flags", {30'd0, dz, ovf}, 32'd0);

        // Directed table
        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, gq, gr, gdz, gov, lat, ok);
            $display("vec %0d inst %0d: 0x%h / 0x%h -> q=0x%h r=0x%h dz=%b ov=%b lat=%0d",
                     i, vecs[i].sel, vecs[i].a, vecs[i].b, gq, gr, gdz, gov, lat);
            if (ok) begin
                chk($sformatf("vec%0d_quotient", i), gq, vecs[i].q);
                chk($sformatf("vec%0d_remainder", i), gr, vecs[i].r);
                chk($sformatf("vec%0d_div_by_zero", i), 32'(gdz), 32'(vecs[i].dz));
                chk($sformatf("vec%0d_overflow", i), 32'(gov), 32'(vecs[i].ov));
                chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            end
        end

        // Consumer stalls for 10 cycles: result must stay frozen
        issue(0, 32'd100, 32'd7, ok);
        if (ok) begin
            wait_valid(lat, ok);
            if (ok) begin
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_quotient", q, 32'd14);
                    chk("hold_remainder", r, 32'd2);
                    chk("hold_out_valid", 32'(vld), 32'd1);
                    chk("hold_in_ready", 32'(rdy), 32'd0);
                end
                consume();
            end
            $display("hold: 100 / 7 held 10 cycles, q=0x%h r=0x%h", q, r);
        end

        // Three back-to-back operations
        begin
            logic [31:0] ba [3] = '{32'd21, 32'hFFFFFFF7, 32'd1000};
            logic [31:0] bb [3] = '{32'd4,  32'd2,        32'd10};
            logic [31:0] bq [3] = '{32'd5,  32'hFFFFFFFC, 32'd100};
            logic [31:0] br [3] = '{32'd1,  32'hFFFFFFFF, 32'd0};
            for (int k = 0; k < 3; k++) begin
                run_op(0, ba[k], bb[k], gq, gr, gdz, gov, lat, ok);
                $display("b2b %0d: 0x%h / 0x%h -> q=0x%h r=0x%h", k, ba[k], bb[k], gq, gr);
                if (ok) begin
                    chk($sformatf("b2b%0d_quotient", k), gq, bq[k]);
                    chk($sformatf("b2b%0d_remainder", k), gr, br[k]);
                end
            end
        end

        // Reset in the middle of CALC
        issue(0, 32'd1000, 32'd3, ok);
        if (ok) begin
            repeat (15) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("midrst_out_valid", 32'(vld), 32'd0);
            chk("midrst_in_ready", 32'(rdy), 32'd1);
            @(negedge clk) rst = 1'b0;
            $display("midrst: reset during CALC, out_valid=%b in_ready=%b", vld, rdy);
        end
        run_op(0, 32'd9, 32'd3, gq, gr, gdz, gov, lat, ok);
        $display("after reset: 9 / 3 -> q=0x%h r=0x%h", gq, gr);
        if (ok) begin
            chk("post_rst_quotient", gq, 32'd3);
            chk("post_rst_remainder", gr, 32'd0);
            chk("post_rst_latency", 32'(lat), 32'd34);
        end

        // Random signed M=32 against the language's truncating / and %
        for (int k = 0; k < 500; k++) begin
            sa = $urandom;
            sb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom;
            if ($urandom_range(0, 1) == 1) sb = -sb;
            if (sb == 0 || (sa == 32'h80000000 && sb == -1)) sb = 3;
            run_op(0, sa, sb, gq, gr, gdz, gov, lat, ok);
            if (ok) begin
                chk($sformatf("rnd32_q %0d/%0d", sa, sb), gq, sa / sb);
                chk($sformatf("rnd32_r %0d/%0d", sa, sb), gr, sa % sb);
            end
        end

        // Random signed M=8
        for (int k = 0; k < 1500; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (b8 == 0 || (a8 == -8'sd128 && b8 == -8'sd1)) b8 = 8'sd5;
            eq8 = a8 / b8;
            er8 = a8 % b8;
            run_op(2, {24'h0, a8}, {24'h0, b8}, gq, gr, gdz, gov, lat, ok);
            if (ok) begin
                chk($sformatf("rnd8_q %0d/%0d", a8, b8), gq, {24'h0, eq8});
                chk($sformatf("rnd8_r %0d/%0d", a8, b8), gr, {24'h0, er8});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
